unidade_controle_multiciclo: RTL and testbench

Multicycle control unit for the RV32I core. It replaces the single-cycle combinational control path with a Moore FSM that sequences one shared ALU and one unified instruction/data memory over several cycles per instruction. It sits between the multicycle operative part and the memory, decoding `opcode`/`funct3`/`funct7` from the instruction register and stalling on a memory ready handshake.

---
 rtl/riscv_pkg.sv | 68 ++++++
 rtl/decodificador_ula.sv | 35 +++
 rtl/unidade_controle_multiciclo.sv | 195 +++++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the multicycle core: opcodes, ALU codes, mux selects and FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package riscv_pkg;

  // Major opcodes, IR[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALU operation codes
  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0011;
  localparam logic [3:0] ALU_SLL    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_SRA    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Instruction class seen by the ALU decoder
  typedef enum logic [1:0] {
    CLS_R  = 2'd0,
    CLS_I  = 2'd1,
    CLS_BR = 2'd2
  } alu_class_t;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC_R = 4'd7,
    ST_EXEC_I = 4'd8,
    ST_ALUWB  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JAL    = 4'd11,
    ST_JALR   = 4'd12,
    ST_LUI    = 4'd13
  } state_t;

endpackage

// File: rtl/decodificador_ula.sv
// ALU decoder: maps funct3/funct7[5] and instruction class to an ALU operation code.
// Latency: purely combinational.
// Backpressure: none.
module decodificador_ula
  import riscv_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  output logic [3:0]  alu_control
);

  // funct3 selects the operation; funct7[5] only distinguishes SUB (R-type) and SRA
  always_comb begin
    alu_control = ALU_ADD;
    if (alu_class == CLS_BR) begin
      // beq/bne compare by subtraction, blt/bge signed, bltu/bgeu unsigned
      if (!funct3[2])     alu_control = ALU_SUB;
      else if (funct3[1]) alu_control = ALU_SLTU;
      else                alu_control = ALU_SLT;
    end else begin
      case (funct3)
        3'b000: alu_control = (alu_class == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_control = ALU_SLL;
        3'b010: alu_control = ALU_SLT;
        3'b011: alu_control = ALU_SLTU;
        3'b100: alu_control = ALU_XOR;
        3'b101: alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RV32I control FSM sequencing one ALU and a unified memory per instruction.
// Latency: 3..5 cycles per instruction plus one per mem_ready=0 cycle in a memory state.
// Backpressure: FETCH/MEMRD/MEMWR hold their request and state until mem_ready.
module unidade_controle_multiciclo
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_q, state_d;
  alu_class_t alu_class;
  logic [3:0] alu_ctrl_dec;
  logic [5:0] funct7_unused;

  // Only funct7[5] matters to RV32I base decoding
  assign funct7_unused = {funct7[6], funct7[4:0]};

  // Decoder class follows the execute state; other states override ALUControl
  assign alu_class = (state_q == ST_EXEC_I) ? CLS_I :
                     (state_q == ST_BRANCH) ? CLS_BR : CLS_R;

  decodificador_ula u_decodificador_ula (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7_b5   (funct7[5]),
    .alu_control (alu_ctrl_dec)
  );

  // State register; async reset drops every output to zero through ST_RST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  // Next-state and output decode; IRWrite/PCWrite/instr_done are qualified by mem_ready where a memory access completes
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_AND;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        // PC+4 computed on the bypass path while the instruction is read
        MemRead    = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALU;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Speculative branch/jump target OldPC+imm lands in ALUOut
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_R:              state_d = ST_EXEC_R;
          OP_I:              state_d = ST_EXEC_I;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
          OP_JALR:           state_d = ST_JALR;
          OP_LUI:            state_d = ST_LUI;
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end

      ST_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        state_d    = (opcode == OP_STORE) ? ST_MEMWR : ST_MEMRD;
      end

      ST_MEMRD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_d = ST_MEMWB;
      end

      ST_MEMWB: begin
        ResultSrc  = RES_MDR;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_EXEC_R: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = alu_ctrl_dec;
        state_d    = ST_ALUWB;
      end

      ST_EXEC_I: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_ctrl_dec;
        state_d    = ST_ALUWB;
      end

      ST_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_BRANCH: begin
        // Datapath gates Branch with its own compare; target already sits in ALUOut
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = alu_ctrl_dec;
        ResultSrc  = RES_ALUOUT;
        Branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_JAL, ST_JALR: begin
        // Link value OldPC+4 goes to the register file on the bypass path; the
        // PC port takes its target from ALUOut (JAL) or the datapath's rs1+imm path (JALR)
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALU;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_LUI: begin
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_PASS_B;
        ResultSrc  = RES_ALU;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for the multicycle control unit.
// Latency: cycle-accurate comparison of every output against a per-instruction phase list.
// Backpressure: random mem_ready stalls in memory phases, random mem_ready elsewhere.
module tb_unidade_controle_multiciclo;

  typedef struct packed {
    logic       pcw;
    logic       br;
    logic       irw;
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic       rw;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [3:0] alu;
    logic       done;
    logic       ill;
  } outs_t;

  typedef struct {
    outs_t base;   // outputs every cycle of the phase
    outs_t extra;  // additional outputs on the mem_ready cycle
    bit    mem;    // phase waits on mem_ready
    bit    fetch;  // phase is the instruction fetch
  } phase_t;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_XOR = 4'b0011;
  localparam logic [3:0] A_SLL = 4'b0100, A_SRL = 4'b0101, A_SUB = 4'b0110, A_SLT = 4'b0111;
  localparam logic [3:0] A_SRA = 4'b1000, A_SLTU = 4'b1001, A_PASSB = 4'b1010;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       PCWrite, Branch, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] ALUControl;
  logic       instr_done, illegal;

  outs_t obs;
  int    errors = 0;
  int    checks = 0;
  int    mrd_mem_cycles = 0;

  assign obs = {PCWrite, Branch, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ALUControl, instr_done, illegal};

  always #5 clk = ~clk;

  unidade_controle_multiciclo dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  // Expected ALU code from the RV32I instruction meaning (cls: 0 R, 1 I, 2 branch)
  function automatic logic [3:0] exp_alu(input int cls, input logic [2:0] f3, input logic b5);
    logic [3:0] tab [8];
    tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (cls == 2) return (f3[2] == 1'b0) ? A_SUB : (f3[1] ? A_SLTU : A_SLT);
    if (cls == 0 && f3 == 3'd0 && b5) return A_SUB;
    if (f3 == 3'd5 && b5) return A_SRA;
    return tab[f3];
  endfunction

  // Runs one instruction from its FETCH cycle; stall counts < 0 are randomized
  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int st_fetch, input int st_mem);
    phase_t q[$];
    phase_t p;
    outs_t  b, e, exp;
    int     stalls;
    bit     first = 1'b1;

    b = '0; e = '0;
    b.mrd = 1; b.sb = 2'b10; b.alu = A_ADD; b.rs = 2'b10;
    e.irw = 1; e.pcw = 1;
    q.push_back('{b, e, 1'b1, 1'b1});

    b = '0; e = '0;
    b.sa = 2'b01; b.sb = 2'b01; b.alu = A_ADD;
    if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111})) b.ill = 1;
    q.push_back('{b, e, 1'b0, 1'b0});

    case (op)
      7'b0000011, 7'b0100011: begin
        b = '0; b.sa = 2'b10; b.sb = 2'b01; b.alu = A_ADD;
        q.push_back('{b, '0, 1'b0, 1'b0});
        if (op == 7'b0000011) begin
          b = '0; b.adr = 1; b.mrd = 1;
          q.push_back('{b, '0, 1'b1, 1'b0});
          b = '0; b.rs = 2'b01; b.rw = 1; b.done = 1;
          q.push_back('{b, '0, 1'b0, 1'b0});
        end else begin
          b = '0; b.adr = 1; b.mwr = 1; e = '0; e.done = 1;
          q.push_back('{b, e, 1'b1, 1'b0});
        end
      end
      7'b0110011, 7'b0010011: begin
        b = '0; b.sa = 2'b10; b.sb = (op == 7'b0010011) ? 2'b01 : 2'b00;
        b.alu = exp_alu((op == 7'b0010011) ? 1 : 0, f3, f7[5]);
        q.push_back('{b, '0, 1'b0, 1'b0});
        b = '0; b.rs = 2'b00; b.rw = 1; b.done = 1;
        q.push_back('{b, '0, 1'b0, 1'b0});
      end
      7'b1100011: begin
        b = '0; b.sa = 2'b10; b.alu = exp_alu(2, f3, f7[5]); b.br = 1; b.done = 1;
        q.push_back('{b, '0, 1'b0, 1'b0});
      end
      7'b1101111, 7'b1100111: begin
        b = '0; b.sa = 2'b01; b.sb = 2'b10; b.alu = A_ADD; b.rs = 2'b10;
        b.rw = 1; b.pcw = 1; b.done = 1;
        q.push_back('{b, '0, 1'b0, 1'b0});
      end
      7'b0110111: begin
        b = '0; b.sb = 2'b01; b.alu = A_PASSB; b.rs = 2'b10; b.rw = 1; b.done = 1;
        q.push_back('{b, '0, 1'b0, 1'b0});
      end
      default: ;
    endcase

    for (int i = 0; i < q.size(); i++) begin
      p = q[i];
      stalls = 0;
      if (p.mem) begin
        stalls = p.fetch ? st_fetch : st_mem;
        if (stalls < 0) stalls = $urandom_range(0, 2);
      end
      for (int k = 0; k <= stalls; k++) begin
        @(negedge clk);
        if (first) begin
          opcode = op; funct3 = f3; funct7 = f7;
          first = 1'b0;
        end
        mem_ready = p.mem ? (k == stalls) : 1'($urandom_range(0, 1));
        #1;
        exp = (p.mem && k == stalls) ? outs_t'(p.base | p.extra) : p.base;
        if (obs.mrd && obs.adr) mrd_mem_cycles++;
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s phase %0d cycle %0d: got %h expected %h", nm, i, k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1;
    opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (obs !== outs_t'(0)) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0", i, obs);
      end
    end
    @(negedge clk);
    reset = 1'b1; #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++;
      $display("FAIL reset_release_rst: got %h expected 0", obs);
    end
    // First FETCH cycle stalled so the next instruction still starts in FETCH
    @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++;
    if (obs.mrd !== 1'b1 || obs.irw !== 1'b0 || obs.pcw !== 1'b0 || obs.adr !== 1'b0) begin
      errors++;
      $display("FAIL reset_then_fetch: got %h expected MemRead=1 IRWrite=0 PCWrite=0", obs);
    end
  endtask

  task automatic test_alu_ops();
    run_instr("add",  7'b0110011, 3'b000, 7'h00, 0, 0);
    run_instr("sub",  7'b0110011, 3'b000, 7'h20, 0, 0);
    run_instr("srai", 7'b0010011, 3'b101, 7'h20, 0, 0);
    run_instr("sra",  7'b0110011, 3'b101, 7'h20, 0, 0);
    run_instr("srli", 7'b0010011, 3'b101, 7'h00, 0, 0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 7'h20, 0, 0);
    run_instr("bltu", 7'b1100011, 3'b110, 7'h00, 0, 0);
    run_instr("lui",  7'b0110111, 3'b011, 7'h15, 0, 0);
    run_instr("jal",  7'b1101111, 3'b000, 7'h00, 0, 0);
    run_instr("jalr", 7'b1100111, 3'b000, 7'h00, 1, 0);
  endtask

  task automatic test_load_stall();
    mrd_mem_cycles = 0;
    run_instr("lw_stall", 7'b0000011, 3'b010, 7'h00, 0, 3);
    checks++;
    if (mrd_mem_cycles != 4) begin
      errors++;
      $display("FAIL lw_memread_hold: got %0d cycles expected 4", mrd_mem_cycles);
    end
    run_instr("sw_stall", 7'b0100011, 3'b010, 7'h00, 2, 2);
  endtask

  task automatic test_illegal();
    run_instr("illegal_7f", 7'h7F, 3'b000, 7'h00, 0, 0);
    run_instr("illegal_00", 7'h00, 3'b111, 7'h7F, 1, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'h7F, 7'h73, 7'h0F, 7'b0110011};
    for (int n = 0; n < 60; n++) begin
      run_instr("random", ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom_range(0, 127)), -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      run_instr("b2b_sw", 7'b0100011, 3'b010, 7'h00, 0, 0);
      run_instr("b2b_beq", 7'b1100011, 3'b000, 7'h00, 0, 0);
    end
  endtask

  task automatic test_reset_in_memwr();
    // Fetch, decode, address, then stall in MEMWR before pulling reset
    opcode = 7'b0100011; funct3 = 3'b010; funct7 = 7'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = (i == 0) ? 1'b1 : 1'b0;
      #1;
    end
    checks++;
    if (obs.mwr !== 1'b1 || obs.adr !== 1'b1) begin
      errors++;
      $display("FAIL memwr_before_reset: got %h expected MemWrite=1 AdrSrc=1", obs);
    end
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++;
      $display("FAIL memwr_async_reset: got %h expected 0", obs);
    end
    @(negedge clk);
    reset = 1'b1; #1;
    checks++;
    if (obs !== outs_t'(0)) begin
      errors++;
      $display("FAIL memwr_restart_rst: got %h expected 0", obs);
    end
    run_instr("after_reset_add", 7'b0110011, 3'b000, 7'h00, 0, 0);
  endtask

  initial begin
    mem_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_load_stall();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_in_memwr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulated time
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
